des_ip_stage: RTL and testbench
===============================

DES_IP_STAGE -- requirements
Module: des_ip_stage

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the accepted-block counter (used only under DES_IP_STAGE_CNT_EN).
REQ-002 The block SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data_in, input, 64 bits: plaintext or ciphertext block; bit 63 is DES bit 1.
REQ-005 The block SHALL have port decrypt_in, input, 1 bit: mode tag carried with the block (1 = decrypt).
REQ-006 The block SHALL have port data_in_valid, input, 1 bit: upstream offers a block.
REQ-007 The block SHALL have port data_in_ready, output, 1 bit: the block can accept a block.
REQ-008 The block SHALL have port ip_l_out, output, 32 bits: L0 = permuted bits [63:32].
REQ-009 The block SHALL have port ip_r_out, output, 32 bits: R0 = permuted bits [31:0].
REQ-010 The block SHALL have port decrypt_out, output, 1 bit: mode tag of the presented block.
REQ-011 The block SHALL have port ip_out_valid, output, 1 bit: a block is presented.
REQ-012 The block SHALL have port ip_out_ready, input, 1 bit: downstream accepts the presented block.
REQ-013 The block SHALL have port blk_cnt_out, output, CNT_W bits: count of accepted blocks; this port exists only under DES_IP_STAGE_CNT_EN.

Function
REQ-014 An input transfer SHALL occur when data_in_valid and data_in_ready are both high on a clock edge; an output transfer SHALL occur when ip_out_valid and ip_out_ready are both high.
REQ-015 The block SHALL apply the standard DES initial permutation IP: {ip_l_out, ip_r_out}[63-k] = data_in[64-IP[k]] for k = 0..63.
REQ-016 The IP table SHALL be 58 50 42 34 26 18 10 2, 60 52 44 36 28 20 12 4, 62 54 46 38 30 22 14 6, 64 56 48 40 32 24 16 8, 57 49 41 33 25 17 9 1, 59 51 43 35 27 19 11 3, 61 53 45 37 29 21 13 5, 63 55 47 39 31 23 15 7.
REQ-017 The permutation SHALL be applied on entry to storage, so stored entries are already permuted.
REQ-018 The block SHALL buffer blocks in a 2-entry FIFO of {permuted block, decrypt tag} with occupancy state EMPTY, ONE or TWO.
REQ-019 In state EMPTY, an input transfer SHALL move the state to ONE; otherwise the state SHALL remain EMPTY.
REQ-020 In state ONE, an input transfer alone SHALL move the state to TWO, an output transfer alone SHALL move it to EMPTY, and simultaneous input and output transfers SHALL keep it at ONE with the new entry presented next cycle.
REQ-021 In state TWO, an output transfer SHALL move the state to ONE; no input transfer is possible in TWO.
REQ-022 data_in_ready SHALL be a registered signal, high exactly when the state is not TWO.
REQ-023 ip_out_valid SHALL be high exactly when the state is not EMPTY.
REQ-024 Latency from an input transfer to ip_out_valid SHALL be 1 cycle when the block is EMPTY.
REQ-025 Blocks SHALL leave in arrival order, with no loss or duplication.
REQ-026 While ip_out_valid is high and ip_out_ready is low, ip_l_out, ip_r_out and decrypt_out SHALL remain stable.
REQ-027 Full-rate throughput of 1 block per cycle SHALL be sustained while ip_out_ready is held high.

Reset
REQ-028 When rst_n_in is low, the state SHALL be EMPTY, ip_out_valid SHALL be 0, data_in_ready SHALL be 0, ip_l_out, ip_r_out and decrypt_out SHALL be 0, and blk_cnt_out SHALL be 0.
REQ-029 data_in_ready SHALL go to 1 on the first clock edge after rst_n_in deasserts.
REQ-030 Assertion of reset mid-operation SHALL discard all buffered blocks immediately.

Configuration
REQ-031 When the macro DES_IP_STAGE_CNT_EN is defined, the block SHALL increment blk_cnt_out by 1 on each input transfer, wrapping from 2^CNT_W-1 to 0.
REQ-032 When DES_IP_STAGE_CNT_EN is not defined, the port blk_cnt_out and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-033 The IP table, the inverse IP table, the block width (64) and the half width (32) SHALL be defined in the shared package des_pkg.
REQ-034 The occupancy-state enum SHALL be defined in des_pkg.
REQ-035 The 2-entry buffer SHALL be implemented as one sub-module, des_skid_buf, parameterised on payload width (65 bits here); the permutation itself SHALL be implemented inline.

Verification
REQ-036 The bench SHALL cover: data_in=0123456789ABCDEF, decrypt_in=0, ip_out_ready=1 -> one cycle later ip_l_out=CC00CCFF, ip_r_out=F0AAF0AA, decrypt_out=0.
REQ-037 The bench SHALL cover: 1000 random blocks through des_ip_stage followed by the existing inverse-permutation stage -> each output equals its original input, in order.
REQ-038 The bench SHALL cover: ip_out_ready=0 while offering three blocks A, B, C -> A and B are accepted, data_in_ready=0 with C held, outputs stay stable at A; then ip_out_ready=1 -> A, B, C emerge in consecutive cycles.
REQ-039 The bench SHALL cover: data_in_valid=1 and ip_out_ready=1 continuously for 64 cycles -> 64 output transfers in 64 consecutive cycles after the 1-cycle latency.
REQ-040 The bench SHALL cover: rst_n_in pulsed low while in state TWO -> ip_out_valid=0 and data_in_ready=0 asynchronously, no stale block appears after release, and blk_cnt_out=0.
REQ-041 The bench SHALL cover, under DES_IP_STAGE_CNT_EN with CNT_W=4: 17 accepted blocks -> blk_cnt_out=1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: block/half widths, IP and inverse-IP tables, and the
// occupancy-state enum of the 2-entry block buffer.
package des_pkg;

  localparam int BLK_W  = 64;
  localparam int HALF_W = 32;

  // Entry k names the 1-based DES input bit that lands on output bit k+1.
  localparam logic [6:0] IP_TABLE [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam logic [6:0] IP_INV_TABLE [64] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Vector index (bit 63 = DES bit 1) of the source bit feeding output position k.
  function automatic logic [5:0] ip_src_bit(input logic [5:0] k);
    return 6'(7'd64 - IP_TABLE[k]);
  endfunction

endpackage

// File: rtl/des_skid_buf.sv
// Two-entry valid/ready FIFO with registered input ready; head entry drives
// the output directly so presented data is a flop output.
module des_skid_buf
  import des_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, ready_d;
  logic         in_fire_s, out_fire_s;

  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign in_ready  = ready_q;

  // Next occupancy, entry moves and registered ready.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    in_fire_s  = in_valid & ready_q;
    out_fire_s = out_valid & out_ready;
    case (state_q)
      OCC_EMPTY: begin
        if (in_fire_s) begin
          head_d  = in_data;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (in_fire_s && out_fire_s) begin
          head_d = in_data;
        end else if (in_fire_s) begin
          tail_d  = in_data;
          state_d = OCC_TWO;
        end else if (out_fire_s) begin
          state_d = OCC_EMPTY;
        end else begin
          state_d = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (out_fire_s) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_TWO;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    ready_d = (state_d != OCC_TWO);
  end

  // State and storage registers; reset clears everything, including ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/des_ip_stage.sv
// DES initial-permutation stage feeding a 2-entry buffer of {L0, R0, decrypt}.
// Optional accepted-block counter enabled by macro DES_IP_STAGE_CNT_EN.
module des_ip_stage
  import des_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [BLK_W-1:0]  data_in,
  input  logic              decrypt_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [HALF_W-1:0] ip_l_out,
  output logic [HALF_W-1:0] ip_r_out,
  output logic              decrypt_out,
  output logic              ip_out_valid,
  input  logic              ip_out_ready
`ifdef DES_IP_STAGE_CNT_EN
  ,
  output logic [CNT_W-1:0]  blk_cnt_out
`endif
);

  logic [BLK_W-1:0] perm_s;
  logic [BLK_W:0]   buf_out_s;

  // Pure wiring: stored entries are already permuted.
  for (genvar k = 0; k < BLK_W; k++) begin : g_ip
    assign perm_s[BLK_W-1-k] = data_in[ip_src_bit(6'(k))];
  end

  des_skid_buf #(
    .W (BLK_W + 1)
  ) u_buf (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .in_data   ({perm_s, decrypt_in}),
    .in_valid  (data_in_valid),
    .in_ready  (data_in_ready),
    .out_data  (buf_out_s),
    .out_valid (ip_out_valid),
    .out_ready (ip_out_ready)
  );

  assign ip_l_out    = buf_out_s[BLK_W:HALF_W+1];
  assign ip_r_out    = buf_out_s[HALF_W:1];
  assign decrypt_out = buf_out_s[0];

`ifdef DES_IP_STAGE_CNT_EN
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  // Count input transfers, wrapping naturally at 2^CNT_W.
  always_comb begin
    if (data_in_valid && data_in_ready) begin
      blk_cnt_d = blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt_out = blk_cnt_q;
`endif

endmodule

// File: tb/tb_des_ip_stage.sv
// Randomized bench for des_ip_stage with a queue-based behavioural model.
module tb_des_ip_stage;

  localparam int CNT_W = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [63:0] data_in = 64'd0;
  logic        decrypt_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [31:0] ip_l_out, ip_r_out;
  logic        decrypt_out;
  logic        ip_out_valid;
  logic        ip_out_ready = 1'b0;
`ifdef DES_IP_STAGE_CNT_EN
  logic [CNT_W-1:0] blk_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  des_ip_stage #(.CNT_W(CNT_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .data_in       (data_in),
    .decrypt_in    (decrypt_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .ip_l_out      (ip_l_out),
    .ip_r_out      (ip_r_out),
    .decrypt_out   (decrypt_out),
    .ip_out_valid  (ip_out_valid),
    .ip_out_ready  (ip_out_ready)
`ifdef DES_IP_STAGE_CNT_EN
    ,
    .blk_cnt_out   (blk_cnt_out)
`endif
  );

  int ip_tab [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                      57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [63:0] perm(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[63-k] = x[64-ip_tab[k]];
    return y;
  endfunction

  function automatic logic [63:0] unperm(input logic [63:0] y);
    logic [63:0] x;
    for (int k = 0; k < 64; k++) x[64-ip_tab[k]] = y[63-k];
    return x;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of presented entries plus original inputs for order check.
  logic [64:0] exp_q [$];
  logic [63:0] orig_q [$];
  bit          rdy_m = 1'b0;
  int          cnt_m = 0;

  initial begin
    bit in_f, out_f;
    forever begin
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) begin
        exp_q.delete();
        orig_q.delete();
        rdy_m = 1'b0;
        cnt_m = 0;
      end else begin
        in_f  = data_in_valid && rdy_m;
        out_f = (exp_q.size() > 0) && ip_out_ready;
        if (out_f) begin
          chk("inverse_order", {1'b0, unperm({ip_l_out, ip_r_out})}, {1'b0, orig_q.pop_front()});
          void'(exp_q.pop_front());
        end
        if (in_f) begin
          exp_q.push_back({perm(data_in), decrypt_in});
          orig_q.push_back(data_in);
          cnt_m++;
        end
        rdy_m = (exp_q.size() < 2);
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        chk("rst_ready", {64'd0, data_in_ready}, 65'd0);
        chk("rst_valid", {64'd0, ip_out_valid}, 65'd0);
        chk("rst_data", {ip_l_out, ip_r_out, decrypt_out}, 65'd0);
      end else begin
        chk("ready", {64'd0, data_in_ready}, {64'd0, rdy_m});
        chk("valid", {64'd0, ip_out_valid}, {64'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("data", {ip_l_out, ip_r_out, decrypt_out}, exp_q[0]);
      end
`ifdef DES_IP_STAGE_CNT_EN
      chk("blk_cnt", {61'd0, blk_cnt_out}, {61'd0, 4'(cnt_m)});
`endif
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, c;
    logic        ad, bd, cd;
    int          n, n_acc, cycles;
    bit          acc;

    // Reset state and model pin.
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_ready", {64'd0, data_in_ready}, 65'd0);
    chk("reset_valid", {64'd0, ip_out_valid}, 65'd0);
    chk("model_pin", {1'b0, perm(64'h0123456789ABCDEF)}, {1'b0, 64'hCC00CCFFF0AAF0AA});
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("ready_after_rst", {64'd0, data_in_ready}, 65'd1);

    // Known vector, one-cycle latency.
    ip_out_ready = 1'b1;
    data_in = 64'h0123456789ABCDEF;
    decrypt_in = 1'b0;
    data_in_valid = 1'b1;
    @(posedge clk_in);
    #1;
    data_in_valid = 1'b0;
    chk("kv_valid", {64'd0, ip_out_valid}, 65'd1);
    chk("kv_l", {33'd0, ip_l_out}, {33'd0, 32'hCC00CCFF});
    chk("kv_r", {33'd0, ip_r_out}, {33'd0, 32'hF0AAF0AA});
    chk("kv_dec", {64'd0, decrypt_out}, 65'd0);
    @(posedge clk_in);
    #1;
    chk("kv_drained", {64'd0, ip_out_valid}, 65'd0);

    // Backpressure: A and B stored, C held off, outputs stable at A.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    ad = 1'($urandom); bd = 1'($urandom); cd = 1'($urandom);
    ip_out_ready = 1'b0;
    data_in = a; decrypt_in = ad; data_in_valid = 1'b1;
    @(posedge clk_in);
    #1;
    data_in = b; decrypt_in = bd;
    @(posedge clk_in);
    #1;
    data_in = c; decrypt_in = cd;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", {64'd0, data_in_ready}, 65'd0);
      chk("bp_hold_a", {ip_l_out, ip_r_out, decrypt_out}, {perm(a), ad});
      @(posedge clk_in);
      #1;
    end
    ip_out_ready = 1'b1;
    @(posedge clk_in);
    #1;
    chk("bp_b", {ip_l_out, ip_r_out, decrypt_out}, {perm(b), bd});
    @(posedge clk_in);
    #1;
    data_in_valid = 1'b0;
    chk("bp_c", {ip_l_out, ip_r_out, decrypt_out}, {perm(c), cd});
    @(posedge clk_in);
    #1;
    chk("bp_empty", {64'd0, ip_out_valid}, 65'd0);

    // Full rate for 64 cycles.
    n = 0;
    data_in = {$urandom, $urandom}; decrypt_in = 1'($urandom); data_in_valid = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk_in);
      #1;
      if (i < 64) begin
        data_in = {$urandom, $urandom}; decrypt_in = 1'($urandom);
      end else begin
        data_in_valid = 1'b0;
      end
      if (ip_out_valid && ip_out_ready) n++;
    end
    chk("full_rate", 65'(n), 65'd64);
    @(posedge clk_in);
    #1;

    // 1000 random blocks with random backpressure; order checked by the model.
    n_acc = 0; cycles = 0;
    while (n_acc < 1000 && cycles < 20000) begin
      if (!data_in_valid && $urandom_range(0, 3) != 0) begin
        data_in = {$urandom, $urandom}; decrypt_in = 1'($urandom); data_in_valid = 1'b1;
      end
      ip_out_ready = ($urandom_range(0, 3) != 0);
      acc = data_in_valid && data_in_ready;
      @(posedge clk_in);
      #1;
      cycles++;
      if (acc) begin
        n_acc++;
        data_in_valid = 1'b0;
      end
    end
    data_in_valid = 1'b0;
    ip_out_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rand_accepted", 65'(n_acc), 65'd1000);
    chk("rand_drained", {64'd0, ip_out_valid}, 65'd0);

    // Reset asserted while two entries are held.
    ip_out_ready = 1'b0;
    data_in = {$urandom, $urandom}; data_in_valid = 1'b1;
    @(posedge clk_in);
    #1;
    data_in = {$urandom, $urandom};
    @(posedge clk_in);
    #1;
    data_in_valid = 1'b0;
    chk("two_ready", {64'd0, data_in_ready}, 65'd0);
    chk("two_valid", {64'd0, ip_out_valid}, 65'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_valid", {64'd0, ip_out_valid}, 65'd0);
    chk("async_ready", {64'd0, data_in_ready}, 65'd0);
    chk("async_data", {ip_l_out, ip_r_out, decrypt_out}, 65'd0);
`ifdef DES_IP_STAGE_CNT_EN
    chk("async_cnt", {61'd0, blk_cnt_out}, 65'd0);
`endif
    @(posedge clk_in);
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    ip_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      chk("no_stale", {64'd0, ip_out_valid}, 65'd0);
    end

`ifdef DES_IP_STAGE_CNT_EN
    // 17 accepted blocks wrap a 4-bit counter to 1.
    data_in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = {$urandom, $urandom};
      @(posedge clk_in);
      #1;
    end
    data_in_valid = 1'b0;
    chk("cnt_17", {61'd0, blk_cnt_out}, 65'd1);
    repeat (2) @(posedge clk_in);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
